nios2_pulse_out: RTL and testbench
==================================

Name: nios2_pulse_out

Overview:
- Avalon-MM slave that drives one CPU-programmed output line: a static idle level, or a timed train of pulses with programmable high time, low time and pulse count.
- Sits on the NIOS2 data master beside the edge-capture input PIOs.
- Raises a maskable level irq when a train completes.

Parameters:
- CNT_W, 16, width of HIGH/LOW/COUNT registers and internal down-counters (2..32).
- RESET_LEVEL, 0, value of the idle-level register and out_port after reset.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous reset, active-low
- address  in  3  word register index
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- out_port  out  1  registered pulse output
- irq  out  1  level interrupt to CPU
- readdata  out  32  registered read data

Behaviour:
- Reset: reset_n asynchronous, active-low; clock clk. All outputs and registers reset asynchronously.
  - State IDLE; out_port=RESET_LEVEL; readdata=0; irq=0.
  - HIGH=1, LOW=1, COUNT=1, irq_mask=0, done=0.
- Write strobe: wr = chipselect & ~write_n. No wait states.
- Read path: readdata is updated every clk from the address mux, independent of chipselect (1-cycle read latency). Unused bits read 0. Fields narrower than 32 are zero-extended; writes use the low CNT_W bits.
- Register map:
  - 0 LEVEL rw: bit0 = idle level.
  - 1 HIGH rw: active cycles per pulse.
  - 2 LOW rw: gap cycles between pulses.
  - 3 COUNT rw: pulses per train.
  - 4 CTRL w: bit0 start, bit1 stop (write-1 strobes). CTRL r: bit0 busy.
  - 5 IRQMASK rw: bit0.
  - 6 STATUS r: bit0 done. Any write to STATUS clears done.
  - 7 reads 0; writes ignored.
- On start: HIGH, LOW and COUNT are latched into shadow counters. HIGH=0 or LOW=0 is treated as 1. Register writes during a train affect only the next train.
- FSM IDLE/ACT/GAP:
  - IDLE, start, COUNT≠0 → ACT next edge; out_port=~level from cycle after the write edge.
  - IDLE, start, COUNT=0 → stays IDLE; done set at next edge; no pulse.
  - ACT holds exactly HIGH cycles. Then:
    - pulses remaining → GAP (out_port=level) for exactly LOW cycles, then ACT.
    - last pulse → IDLE; done set on the same edge.
- busy = (state≠IDLE).
- Start while busy: ignored.
- Stop while busy: IDLE next edge; out_port=level; done not set.
- Start and stop in the same write: stop wins.
- Done set and STATUS write in the same cycle: set wins.
- LEVEL write while idle: out_port follows on the next edge. LEVEL write during a train: the current train uses the new level from the next edge (no latching).
- irq = done & irq_mask, combinational from registers.
- Reset mid-train: out_port returns to RESET_LEVEL asynchronously; the train is abandoned.
- Pulse period = HIGH+LOW cycles. Total train = COUNT*HIGH + (COUNT-1)*LOW cycles.

Optional Feature:
- Macro PULSE_OUT_PER_PULSE_IRQ_EN.
- Defined:
  - STATUS bit1 "pulse" is set at the end of every ACT phase, including the last.
  - IRQMASK bit1 enables it; irq = |(STATUS[1:0] & IRQMASK[1:0]).
  - A STATUS write clears only the bits written as 1 (bit0 and bit1 independently); set wins over clear.
- Undefined:
  - STATUS and IRQMASK bit1 read 0; writes to bit1 are ignored.
  - Any STATUS write clears done.

Test Plan:
- Reset release, read all addresses → out_port=0, irq=0; readdata 1,1,1,0,0,0,0 for addr1..7; LEVEL reads 0.
- HIGH=3, LOW=2, COUNT=2, start → out_port high cycles 1-3, low 4-5, high 6-8 after the write edge. busy=1 through cycle 8; done=1 at cycle 9.
- IRQMASK=1, COUNT=1, HIGH=5, start → irq rises with done. Write STATUS → irq=0 next cycle. Repeat with the STATUS write landing on the done edge → done stays 1.
- LEVEL=1, HIGH=4, COUNT=3, start, stop at cycle 2 → out_port=0 for cycles 1-2, then 1. done=0; busy=0.
- COUNT=0 start → no pulse, done=1 next cycle. Start+stop written together (CTRL=3) while idle → nothing happens.
- HIGH=0, LOW=0, COUNT=3 → pulses 1 cycle high, 1 low. Start again while busy → ignored; the train ends after exactly 3 pulses.

Source files
------------

// File: rtl/nios2_pulse_out.sv
// Avalon-MM pulse-train generator: static idle level or HIGH/LOW/COUNT timed pulses, maskable done irq.
// Optional macro PULSE_OUT_PER_PULSE_IRQ_EN adds a per-pulse status bit (STATUS[1]) enabled by IRQMASK[1].
module nios2_pulse_out #(
  parameter int   CNT_W       = 16,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic        out_port,
  output logic        irq,
  output logic [31:0] readdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACT  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [2:0] A_LEVEL  = 3'd0;
  localparam logic [2:0] A_HIGH   = 3'd1;
  localparam logic [2:0] A_LOW    = 3'd2;
  localparam logic [2:0] A_COUNT  = 3'd3;
  localparam logic [2:0] A_CTRL   = 3'd4;
  localparam logic [2:0] A_MASK   = 3'd5;
  localparam logic [2:0] A_STATUS = 3'd6;

`ifdef PULSE_OUT_PER_PULSE_IRQ_EN
  localparam int IRQ_W = 2;
`else
  localparam int IRQ_W = 1;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state, state_nxt;
  logic             level_reg, level_nxt;
  logic [CNT_W-1:0] high_reg, low_reg, count_reg;
  logic [CNT_W-1:0] high_eff, low_eff;
  logic [CNT_W-1:0] sh_high, sh_low;
  logic [CNT_W-1:0] phase_cnt, phase_nxt;
  logic [CNT_W-1:0] pulses_left, pulses_nxt;
  logic [IRQ_W-1:0] irq_mask, status_reg, status_set, status_clr;
  logic             wr, wr_ctrl, wr_status, start_req, stop_req;
  logic             load_shadow, done_set, pulse_end;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr && (address == A_CTRL);
  assign wr_status = wr && (address == A_STATUS);
  // Stop has priority, so a combined start+stop write never launches a train.
  assign start_req = wr_ctrl & writedata[0] & ~writedata[1];
  assign stop_req  = wr_ctrl & writedata[1];

  assign high_eff  = (high_reg == '0) ? CNT_ONE : high_reg;
  assign low_eff   = (low_reg  == '0) ? CNT_ONE : low_reg;
  assign level_nxt = (wr && (address == A_LEVEL)) ? writedata[0] : level_reg;
  assign unused_wd = ^writedata;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase_cnt;
    pulses_nxt  = pulses_left;
    load_shadow = 1'b0;
    done_set    = 1'b0;
    pulse_end   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_req) begin
          if (count_reg != '0) begin
            state_nxt   = ST_ACT;
            phase_nxt   = high_eff;
            pulses_nxt  = count_reg;
            load_shadow = 1'b1;
          end else begin
            done_set = 1'b1;
          end
        end
      end
      ST_ACT: begin
        if (phase_cnt == CNT_ONE) begin
          pulse_end = 1'b1;
          if (pulses_left == CNT_ONE) begin
            state_nxt = ST_IDLE;
            done_set  = 1'b1;
          end else begin
            state_nxt  = ST_GAP;
            phase_nxt  = sh_low;
            pulses_nxt = pulses_left - CNT_ONE;
          end
        end else begin
          phase_nxt = phase_cnt - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (phase_cnt == CNT_ONE) begin
          state_nxt = ST_ACT;
          phase_nxt = sh_high;
        end else begin
          phase_nxt = phase_cnt - CNT_ONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // An aborted train never reports completion.
    if (stop_req && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      done_set  = 1'b0;
      pulse_end = 1'b0;
    end
  end

`ifdef PULSE_OUT_PER_PULSE_IRQ_EN
  assign status_set = {pulse_end, done_set};
  assign status_clr = wr_status ? writedata[1:0] : 2'b00;
`else
  assign status_set = done_set;
  assign status_clr = wr_status;
  logic unused_pulse;
  assign unused_pulse = pulse_end;
`endif

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      out_port    <= RESET_LEVEL;
      level_reg   <= RESET_LEVEL;
      high_reg    <= CNT_ONE;
      low_reg     <= CNT_ONE;
      count_reg   <= CNT_ONE;
      sh_high     <= CNT_ONE;
      sh_low      <= CNT_ONE;
      phase_cnt   <= '0;
      pulses_left <= '0;
      irq_mask    <= '0;
      status_reg  <= '0;
      readdata    <= '0;
    end else begin
      state       <= state_nxt;
      phase_cnt   <= phase_nxt;
      pulses_left <= pulses_nxt;
      level_reg   <= level_nxt;
      out_port    <= (state_nxt == ST_ACT) ? ~level_nxt : level_nxt;
      status_reg  <= status_set | (status_reg & ~status_clr);
      readdata    <= rd_mux;
      if (load_shadow) begin
        sh_high <= high_eff;
        sh_low  <= low_eff;
      end
      if (wr && (address == A_HIGH))  high_reg  <= writedata[CNT_W-1:0];
      if (wr && (address == A_LOW))   low_reg   <= writedata[CNT_W-1:0];
      if (wr && (address == A_COUNT)) count_reg <= writedata[CNT_W-1:0];
      if (wr && (address == A_MASK))  irq_mask  <= writedata[IRQ_W-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      A_LEVEL:  rd_mux[0]           = level_reg;
      A_HIGH:   rd_mux[CNT_W-1:0]   = high_reg;
      A_LOW:    rd_mux[CNT_W-1:0]   = low_reg;
      A_COUNT:  rd_mux[CNT_W-1:0]   = count_reg;
      A_CTRL:   rd_mux[0]           = (state != ST_IDLE);
      A_MASK:   rd_mux[IRQ_W-1:0]   = irq_mask;
      A_STATUS: rd_mux[IRQ_W-1:0]   = status_reg;
      default:  rd_mux = '0;
    endcase
  end

  assign irq = |(status_reg & irq_mask);

endmodule

// File: tb/tb_nios2_pulse_out.sv
// Scoreboard bench for nios2_pulse_out (default build): a train-level model predicts out_port and register reads.
module tb_nios2_pulse_out;

  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic        out_port, irq;
  logic [31:0] readdata;

  nios2_pulse_out #(.CNT_W(CNT_W), .RESET_LEVEL(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .out_port(out_port), .irq(irq),
    .readdata(readdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        out_q[$];
  logic [31:0] rd_q[$];
  logic        rd_req = 1'b0;

  // Reference model: register values plus the edge at which the running train ends.
  logic             m_level = 1'b0, m_mask = 1'b0, m_done = 1'b0, train_on = 1'b0;
  logic [CNT_W-1:0] m_high = 1, m_low = 1, m_count = 1;
  int               end_e = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void settle();
    if (train_on && cyc >= end_e) begin
      train_on = 1'b0;
      m_done   = 1'b1;
    end
  endfunction

  function automatic void expect_level();
    out_q.delete();
    out_q.push_back(m_level);
    out_q.push_back(m_level);
  endfunction

  // Expected waveform: COUNT pulses of HIGH cycles at ~level separated by LOW cycles at level.
  function automatic void launch(input int e);
    int h, l, c;
    train_on = 1'b1;
    out_q.delete();
    if (m_count == '0) begin
      end_e = e;
    end else begin
      h = (m_high == '0) ? 1 : int'(m_high);
      l = (m_low  == '0) ? 1 : int'(m_low);
      c = int'(m_count);
      end_e = e + c * h + (c - 1) * l;
      for (int p = 0; p < c; p++) begin
        for (int i = 0; i < h; i++) out_q.push_back(~m_level);
        if (p < c - 1) for (int i = 0; i < l; i++) out_q.push_back(m_level);
      end
    end
    out_q.push_back(m_level);
    out_q.push_back(m_level);
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      3'd0: r[0] = m_level;
      3'd1: r[CNT_W-1:0] = m_high;
      3'd2: r[CNT_W-1:0] = m_low;
      3'd3: r[CNT_W-1:0] = m_count;
      3'd4: r[0] = train_on;
      3'd5: r[0] = m_mask;
      3'd6: r[0] = m_done;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    int e;
    e = cyc + 1;
    settle();
    case (a)
      3'd0: begin m_level = d[0]; expect_level(); end
      3'd1: m_high  = d[CNT_W-1:0];
      3'd2: m_low   = d[CNT_W-1:0];
      3'd3: m_count = d[CNT_W-1:0];
      3'd4: begin
        if (d[1]) begin
          if (train_on) begin train_on = 1'b0; expect_level(); end
        end else if (d[0] && !train_on) begin
          launch(e);
        end
      end
      3'd5: m_mask = d[0];
      3'd6: m_done = 1'b0;
      default: ;
    endcase
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a);
    settle();
    address = a;
    rd_q.push_back(model_read(a));
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic chk_irq();
    settle();
    check("irq", {31'd0, irq}, {31'd0, m_done & m_mask});
    @(negedge clk);
  endtask

  task automatic finish_train();
    int guard;
    guard = 0;
    settle();
    while (train_on && guard < 200) begin
      @(negedge clk);
      settle();
      guard++;
    end
    if (train_on) check("train_end_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: pops expectations whenever the DUT presents read data or a tracked out_port cycle.
  initial begin
    logic [31:0] exp_rd;
    logic        exp_out;
    forever begin
      @(posedge clk);
      #1;
      if (rd_req) begin
        if (rd_q.size() == 0) check("rd_q_underflow", 32'd0, 32'd1);
        else begin
          exp_rd = rd_q.pop_front();
          check($sformatf("readdata@a%0d", address), readdata, exp_rd);
        end
      end
      if (out_q.size() != 0) begin
        exp_out = out_q.pop_front();
        check("out_port", {31'd0, out_port}, {31'd0, exp_out});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running (got timeout, expected completion)");
    $fatal(1);
  end

  initial begin
    int stop_at, k, sel;
    @(negedge clk);
    check("reset_out_port", {31'd0, out_port}, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_readdata", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 8; a++) rd(3'(a));

    // HIGH=3, LOW=2, COUNT=2: busy polled through the whole train and past it.
    wr(3'd1, 32'd3); wr(3'd2, 32'd2); wr(3'd3, 32'd2);
    wr(3'd4, 32'd1);
    for (int i = 0; i < 10; i++) rd(3'd4);
    rd(3'd6);

    // irq follows done; a STATUS write clears it, unless it lands on the done edge.
    wr(3'd6, 32'd0); wr(3'd5, 32'd1); wr(3'd3, 32'd1); wr(3'd1, 32'd5);
    wr(3'd4, 32'd1);
    for (int i = 0; i < 7; i++) chk_irq();
    wr(3'd6, 32'd1);
    chk_irq();
    wr(3'd4, 32'd1);
    while (cyc < end_e - 1) @(negedge clk);
    wr(3'd6, 32'd1);
    rd(3'd6);
    chk_irq();

    // Stop mid-train with LEVEL=1.
    wr(3'd6, 32'd1); wr(3'd5, 32'd0);
    wr(3'd0, 32'd1); wr(3'd1, 32'd4); wr(3'd3, 32'd3);
    wr(3'd4, 32'd1);
    @(negedge clk);
    wr(3'd4, 32'd2);
    rd(3'd6); rd(3'd4);
    wr(3'd0, 32'd0);

    // COUNT=0 start, then start+stop together while idle.
    wr(3'd3, 32'd0); wr(3'd4, 32'd1);
    rd(3'd6);
    wr(3'd6, 32'd1); wr(3'd3, 32'd2);
    wr(3'd4, 32'd3);
    rd(3'd4); rd(3'd6);

    // HIGH=0/LOW=0 behave as 1; a start while busy is ignored.
    wr(3'd1, 32'd0); wr(3'd2, 32'd0); wr(3'd3, 32'd3);
    wr(3'd4, 32'd1);
    @(negedge clk);
    wr(3'd4, 32'd1);
    finish_train();
    rd(3'd6); rd(3'd4);

    // Randomized trains with mid-train traffic and occasional stops.
    for (int it = 0; it < 24; it++) begin
      wr(3'd0, {$urandom()} & 32'h1);
      wr(3'd1, ($urandom() & 32'hFFFF_0000) | $urandom_range(0, 4));
      wr(3'd2, ($urandom() & 32'hFFFF_0000) | $urandom_range(0, 4));
      wr(3'd3, $urandom_range(0, 3));
      wr(3'd5, $urandom());
      wr(3'd6, 32'd1);
      wr(3'd4, 32'd1);
      stop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : -1;
      k = 1;
      settle();
      while (train_on && k < 80) begin
        sel = $urandom_range(0, 4);
        if (k == stop_at) wr(3'd4, 32'd2);
        else if (sel == 0) @(negedge clk);
        else if (sel == 1) rd(3'($urandom_range(0, 7)));
        else if (sel == 2) wr(3'($urandom_range(1, 3)), $urandom_range(0, 5));
        else if (sel == 3) wr(3'd4, 32'd1);
        else chk_irq();
        k++;
        settle();
      end
      rd(3'd6); rd(3'd4);
      chk_irq();
    end

    repeat (4) @(negedge clk);
    check("out_q_drained", out_q.size(), 32'd0);
    check("rd_q_drained", rd_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
